// File: rtl/max7219_spi_tx_if.sv
// ---------------------------------------------------------------------------
// max7219_spi_tx_if
// Avalon-MM slave register bus for the MAX7219 SPI transmitter.
//
// Signals:
//   address     [1:0]   register select
//   chipselect          slave select
//   write_n             active-low write strobe
//   writedata   [31:0]  write data
//   readdata    [31:0]  read data (driven combinationally by the slave)
//
// Modports:
//   master  - bus owner (CPU bridge / testbench)
//   slave   - max7219_spi_tx
// ---------------------------------------------------------------------------
interface max7219_spi_tx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/max7219_spi_tx.sv
// ---------------------------------------------------------------------------
// max7219_spi_tx
// Serialises 16-bit MAX7219 command words (address byte + data byte) to a
// daisy chain of N_DEV drivers. CPU writes are buffered in a TX FIFO; a frame
// of N_DEV words is shifted MSB first, word 0 first, with LOAD held low for
// the whole frame so that its rising edge latches one command per device.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   bus         Avalon-MM slave (max7219_spi_tx_if.slave)
//                 0 TXDATA  (W)  push writedata[15:0]; reads 0
//                 1 STATUS  (R)  [0] busy [1] full [2] empty [3] overflow
//                                [4] done (IRQ build) [11:8] FIFO level
//                           (W)  any write clears overflow (and done)
//                 2 CONTROL (RW) [0] enable [1] irq_en (IRQ build)
//                 3         reads 0, writes ignored
//   spi_sclk    serial clock to MAX7219 CLK
//   spi_mosi    serial data to MAX7219 DIN
//   spi_load_n  MAX7219 LOAD/CS, low during a frame
//   irq         (only with MAX7219_SPI_TX_IRQ_EN) registered done & irq_en
//
// Build option: define MAX7219_SPI_TX_IRQ_EN to add the irq output, the
// sticky done flag and the irq_en control bit.
// ---------------------------------------------------------------------------
module max7219_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int N_DEV      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  max7219_spi_tx_if.slave bus,
  output logic spi_sclk,
  output logic spi_mosi,
  output logic spi_load_n
`ifdef MAX7219_SPI_TX_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(16 * N_DEV) + 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   word_q, word_d;
  logic [15:0]        shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               enable_q, enable_d;
  logic [15:0]        mem_q [FIFO_DEPTH];

  logic wr_en, push_req, push_ok, pop, full, empty, busy, done_set;
  logic div_last, latch_last;
  logic done_bit, irq_en_bit;
  logic [3:0] level_nib;
  logic [15:0] fifo_head;
  logic unused_wdata;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign push_req  = wr_en && (bus.address == 2'd0);
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  // A full FIFO still accepts a push when a word leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign busy      = (state_q != S_IDLE);
  assign fifo_head = mem_q[rd_ptr_q];
  assign unused_wdata = ^bus.writedata[31:16];

  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
  assign latch_last = (div_q == DIV_W'(2 * CLK_DIV - 1));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- FIFO storage (no reset, plain RAM) ----------------
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.writedata[15:0];
  end

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // ---------------- Control / status registers ----------------
  always_comb begin
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_en && bus.address == 2'd2) enable_d = bus.writedata[0];
    if (wr_en && bus.address == 2'd1) overflow_d = 1'b0;
    else if (push_req && !push_ok)    overflow_d = 1'b1;
  end

  // ---------------- Frame FSM ----------------
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    word_d   = word_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        // Only start once a whole frame is buffered, so mid-frame pops
        // can never find the FIFO empty.
        if (enable_q && level_q >= LVL_W'(N_DEV)) begin
          state_d = S_SETUP;
          shift_d = fifo_head;
          pop     = 1'b1;
          bit_d   = '0;
          word_d  = CNT_W'(1);
        end
      end
      S_SETUP: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          state_d = S_SHIFT_LO;
          bit_d   = bit_q + 1'b1;
          if (bit_q[3:0] == 4'hF) begin
            // Word boundary: fetch the next word unless the frame is done,
            // in which case mosi holds the last bit.
            if (word_q != CNT_W'(N_DEV)) begin
              shift_d = fifo_head;
              pop     = 1'b1;
              word_d  = word_q + 1'b1;
            end
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
      end
      S_SHIFT_LO: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last)
          state_d = (bit_q == CNT_W'(16 * N_DEV)) ? S_LATCH : S_SHIFT_HI;
      end
      S_LATCH: begin
        div_d = latch_last ? '0 : div_q + 1'b1;
        if (latch_last) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
    end
  end

  // Pins decode straight from the state register, so reset forces them
  // to idle levels immediately.
  assign spi_sclk   = (state_q == S_SHIFT_HI);
  assign spi_load_n = (state_q == S_IDLE) || (state_q == S_LATCH);
  assign spi_mosi   = (state_q == S_SETUP || state_q == S_SHIFT_HI ||
                       state_q == S_SHIFT_LO) ? shift_q[15] : 1'b0;

  // ---------------- Optional interrupt ----------------
`ifdef MAX7219_SPI_TX_IRQ_EN
  logic irq_en_q, done_q, irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd2) irq_en_q <= bus.writedata[1];
      if (done_set)                          done_q <= 1'b1;
      else if (wr_en && bus.address == 2'd1) done_q <= 1'b0;
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq        = irq_q;
  assign done_bit   = done_q;
  assign irq_en_bit = irq_en_q;
`else
  logic unused_done;
  assign unused_done = done_set;
  assign done_bit    = 1'b0;
  assign irq_en_bit  = 1'b0;
`endif

  // ---------------- Read mux ----------------
  generate
    if (LVL_W >= 4) begin : g_lvl_trunc
      assign level_nib = level_q[3:0];
    end else begin : g_lvl_ext
      assign level_nib = {{(4 - LVL_W){1'b0}}, level_q};
    end
  endgenerate

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1: bus.readdata = {20'b0, level_nib, 3'b0, done_bit, overflow_q,
                            empty, full, busy};
      2'd2: bus.readdata = {30'b0, irq_en_bit, enable_q};
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_max7219_spi_tx.sv
module tb_max7219_spi_tx;
  localparam int CLK_DIV   = 2;
  localparam int N_DEV     = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = CLK_DIV * (1 + 32 * N_DEV);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sclk, spi_mosi, spi_load_n;

  always #5 clk = ~clk;

  max7219_spi_tx_if bif();

  max7219_spi_tx #(.CLK_DIV(CLK_DIV), .N_DEV(N_DEV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bif.slave),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_load_n (spi_load_n)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  bit [15:0] mq[$];
  bit        ovf_m = 1'b0;

  function automatic void model_push(input bit [15:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else ovf_m = 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    int lvl;
    lvl = mq.size();
    return {20'b0, 4'(lvl), 3'b0, 1'b0, ovf_m, (lvl == 0), (lvl == DEPTH), busy};
  endfunction

  // ---------------- Pin monitor ----------------
  int        frames_seen = 0;
  int        nbits = 0;
  int        low_cycles = 0;
  bit        in_frame = 1'b0;
  logic      prev_sclk = 1'b0;
  logic      prev_load = 1'b1;
  logic [15:0] cur_word = '0;
  bit [15:0] cap[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame   = 1'b0;
      nbits      = 0;
      low_cycles = 0;
      cap.delete();
      prev_sclk  = 1'b0;
      prev_load  = 1'b1;
    end else begin
      if (prev_load && !spi_load_n) begin
        in_frame   = 1'b1;
        nbits      = 0;
        low_cycles = 0;
        cap.delete();
      end
      if (!spi_load_n) low_cycles++;
      if (!prev_sclk && spi_sclk) begin
        check_eq("sclk_in_frame", {31'b0, spi_load_n}, 32'd0);
        cur_word = {cur_word[14:0], spi_mosi};
        nbits++;
        if (nbits % 16 == 0) cap.push_back(cur_word);
      end
      if (!prev_load && spi_load_n && in_frame) begin
        in_frame = 1'b0;
        frames_seen++;
        check_eq("frame_len", low_cycles, FRAME_CYC);
        check_eq("frame_bits", nbits, 16 * N_DEV);
        check_eq("model_has_words", {31'b0, mq.size() >= N_DEV}, 32'd1);
        for (int w = 0; w < N_DEV; w++) begin
          bit [15:0] got_w, exp_w;
          got_w = (w < cap.size()) ? cap[w] : 16'h0;
          exp_w = (mq.size() > 0) ? mq.pop_front() : 16'h0;
          check_eq($sformatf("frame%0d_word%0d", frames_seen, w), got_w, exp_w);
        end
        $display("frame %0d: %0d bits, load_n low %0d cycles, words %p",
                 frames_seen, nbits, low_cycles, cap);
      end
      prev_sclk = spi_sclk;
      prev_load = spi_load_n;
    end
  end

  // ---------------- Bus tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.address    = a;
    bif.chipselect = 1'b1;
    bif.write_n    = 1'b0;
    bif.writedata  = d;
    @(negedge clk);
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bif.address = a;
    #1;
    d = bif.readdata;
  endtask

  task automatic push_word(input bit [15:0] w);
    bus_write(2'd0, {16'($urandom), w});
    model_push(w);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c;
    c = 0;
    while (frames_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    check_eq("frames_done", frames_seen, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- Stimulus ----------------
  initial begin
    logic [31:0] r;
    int base, n, f, c;
    bit [15:0] w;

    bif.address = 2'd0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    bus_read(2'd1, r); check_eq("rst_status", r, exp_status(0));
    bus_read(2'd2, r); check_eq("rst_control", r, 32'd0);
    bus_read(2'd0, r); check_eq("rd_txdata", r, 32'd0);
    bus_read(2'd3, r); check_eq("rd_reg3", r, 32'd0);
    check_eq("rst_pins", {29'b0, spi_load_n, spi_sclk, spi_mosi}, 32'b100);

    // Partial frame must not start; the completing word starts it
    bus_write(2'd2, 32'd1);
    for (int k = 0; k < N_DEV - 1; k++) begin
      w = 16'($urandom);
      push_word(w);
    end
    repeat (40) @(negedge clk);
    #1;
    check_eq("no_start_partial", {31'b0, spi_load_n}, 32'd1);
    bus_read(2'd1, r); check_eq("status_partial", r, exp_status(0));
    base = frames_seen;
    push_word(16'h0C01);
    repeat (2) @(negedge clk);
    #1;
    check_eq("start_after_fill", {31'b0, spi_load_n}, 32'd0);
    wait_frames(base + 1, FRAME_CYC + 40);
    repeat (10) @(negedge clk);
    bus_read(2'd1, r); check_eq("status_after_frame", r, exp_status(0));
    $display("step partial/fill: frames=%0d", frames_seen);

    // Overflow with enable off
    bus_write(2'd2, 32'd0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      w = 16'($urandom);
      push_word(w);
    end
    bus_read(2'd1, r); check_eq("status_overflow", r, exp_status(0));
    bus_write(2'd1, 32'($urandom));
    ovf_m = 1'b0;
    bus_read(2'd1, r); check_eq("status_ovf_clear", r, exp_status(0));
    $display("step overflow: level=%0d", mq.size());

    // Enable dropped mid-frame: current frame completes, no new one
    base = frames_seen;
    bus_write(2'd2, 32'd1);
    c = 0;
    while (spi_load_n && c < 10) begin @(negedge clk); c++; end
    check_eq("frame_started", {31'b0, spi_load_n}, 32'd0);
    bus_write(2'd2, 32'd0);
    wait_frames(base + 1, FRAME_CYC + 40);
    repeat (FRAME_CYC + 40) @(negedge clk);
    check_eq("single_frame", frames_seen, base + 1);
    bus_read(2'd1, r); check_eq("status_after_disable", r, exp_status(0));
    $display("step disable mid-frame: frames=%0d level=%0d", frames_seen, mq.size());

    // Randomised fill / drain rounds
    for (int it = 0; it < 6; it++) begin
      bus_write(2'd2, 32'd0);
      n = $urandom_range(0, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        push_word(w);
      end
      bus_read(2'd1, r); check_eq("status_fill", r, exp_status(0));
      if (ovf_m) begin
        bus_write(2'd1, 32'($urandom));
        ovf_m = 1'b0;
        bus_read(2'd1, r); check_eq("status_ovf_clr", r, exp_status(0));
      end
      f = mq.size() / N_DEV;
      base = frames_seen;
      bus_write(2'd2, 32'd1);
      wait_frames(base + f, f * (FRAME_CYC + 20) + 40);
      repeat (10) @(negedge clk);
      bus_read(2'd1, r); check_eq("status_drain", r, exp_status(0));
      bus_read(2'd2, r); check_eq("control_rb", r, 32'd1);
      $display("round %0d: pushed=%0d frames=%0d left=%0d", it, n, f, mq.size());
    end

    // Reset at the 5th SCLK rise of a frame
    bus_write(2'd2, 32'd0);
    while (mq.size() < N_DEV) begin
      w = 16'($urandom);
      push_word(w);
    end
    bus_write(2'd2, 32'd1);
    c = 0;
    do begin
      @(negedge clk); #1; c++;
    end while (!(in_frame && nbits >= 5) && c < FRAME_CYC + 20);
    check_eq("reached_5th_rise", {31'b0, in_frame && nbits >= 5}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_pins", {29'b0, spi_load_n, spi_sclk, spi_mosi}, 32'b100);
    mq.delete();
    ovf_m = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, r); check_eq("status_after_rst", r, 32'h004);
    bus_read(2'd2, r); check_eq("control_after_rst", r, 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check_eq("idle_after_rst", {31'b0, spi_load_n}, 32'd1);
    $display("step mid-frame reset: frames=%0d", frames_seen);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/max7219_spi_tx.md
Name: max7219_spi_tx

Overview:
Avalon-MM slave SPI transmitter that serialises 16-bit MAX7219 command words (address byte + data byte) to a daisy chain of N_DEV LED-matrix drivers. It buffers CPU writes in a small TX FIFO and drives SCLK/DIN. It frames every N_DEV words with the LOAD (CS) line, so the rising edge of LOAD latches one command into every device in the chain. It sits on the HPS lightweight bridge beside the PIO registers and is the stage that consumes CPU-produced display data and pushes it to the matrix pins.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥1.
- N_DEV, 4: daisy-chained devices, i.e. 16-bit words per frame; legal range ≥1.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥N_DEV.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero-extended
- spi_sclk  out  1  serial clock to MAX7219 CLK
- spi_mosi  out  1  serial data to MAX7219 DIN
- spi_load_n  out  1  MAX7219 LOAD/CS, low during a frame

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is on posedge clk.
- Register map (write = chipselect & ~write_n):
  - 0 TXDATA: a write pushes writedata[15:0]; reads return 0.
  - 1 STATUS (read): bit0 busy (FSM≠IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] FIFO level. Any write to STATUS clears overflow.
  - 2 CONTROL (R/W): bit0 enable. Reset value 0.
  - 3: reads 0; writes ignored.
- FIFO: a push when full is dropped and sets overflow; the FIFO contents are unchanged. A push and a pop in the same cycle are both honoured (level unchanged) and never flag overflow.
- FSM: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → LATCH → IDLE.
  - IDLE: spi_load_n=1, sclk=0. Leave when enable=1 and level≥N_DEV.
  - SETUP: pop word 0 into a 16-bit shift register; load_n=0; mosi=bit15. Hold CLK_DIV cycles.
  - SHIFT_HI: sclk=1 for CLK_DIV cycles (device samples on this rising edge).
  - SHIFT_LO: sclk=0 for CLK_DIV cycles. On entry, mosi advances to the next bit; after bit0 of words 0..N_DEV-2, pop the next word and present its bit15. After the final bit of word N_DEV-1, mosi holds and the state goes to LATCH at the end of the phase.
  - LATCH: load_n=1 (rising edge latches the command), mosi=0. Hold 2*CLK_DIV cycles, then go to IDLE.
- Frame timing: load_n low for exactly CLK_DIV*(1+32*N_DEV) cycles; exactly 16*N_DEV SCLK rising edges per frame; bits go MSB first, word 0 first (word 0 ends up in the farthest device).
- enable cleared mid-frame: the current frame completes; no new frame starts.
- Reset, including mid-frame: load_n=1, sclk=0, mosi=0, FIFO empty, overflow=0, enable=0, FSM=IDLE, readdata reflects the reset values.
- Bit and word counters are sized $clog2(16*N_DEV)+1. The half-period counter wraps from CLK_DIV-1 to 0.

Optional Feature:
MAX7219_SPI_TX_IRQ_EN:
- Defined: adds output port irq (1 bit), CONTROL bit1 irq_en, and STATUS bit4 done. done is a sticky flag set on the LATCH→IDLE transition and cleared by any STATUS write. irq = done & irq_en, registered, reset 0.
- Undefined: no irq port; CONTROL bit1 and STATUS bit4 read 0.

Test Plan:
1. CLK_DIV=2, N_DEV=1, enable=1; write TXDATA 0x0C01 → load_n low 66 cycles; 16 sclk rises sample 0000110000000001; load_n rises; STATUS busy returns to 0 4 cycles later.
2. N_DEV=4; write 0x0F00, 0x0A05, 0x0B07, 0x0C01 with enable=0 → no activity, level=4; set enable → one frame of 64 bits in write order, one load_n pulse, FIFO empty afterwards.
3. FIFO_DEPTH=8, enable=0; write 9 words → full=1, overflow=1, level=8; write STATUS → overflow=0, full stays 1.
4. N_DEV=4, only 3 words written, enable=1 → load_n stays 1; 4th write → frame starts within 2 cycles.
5. Assert reset_n at the 5th sclk rise of a frame → load_n=1, sclk=0, mosi=0 asynchronously; STATUS=0x004 after release.
6. With IRQ_EN: irq_en=1, one frame → irq=1 one cycle after LATCH ends; STATUS write → irq=0.
